rank_order_encoder: RTL
=======================

Name: rank_order_encoder

Overview:
Parametrised successor to the image encoder. Converts a latched pixel image into a rank-order spike train and emits one AER event per pixel over a 4-phase REQ/ACK link. Integrates the sort and AER stages in one FSM and adds:
- a minimum-value threshold
- a top-K spike limit
- ascending or descending rank mode
- busy and spike-count status

It sits between the image source and the SNN core's AER input.

Parameters:
IMAGE_SIZE, 5, number of pixels/channels.
IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), index width minus one; address ports are [IMAGE_SIZE_BITS:0].
PIXEL_MAX_VALUE, 10, largest pixel value.
PIXEL_BITS, $clog2(PIXEL_MAX_VALUE), pixel width minus one; pixel ports are [PIXEL_BITS:0].

Ports:
CLK  in  1  clock; all logic on rising edge.
RST  in  1  synchronous, active-high reset.
IMAGE  in  [PIXEL_BITS:0] x IMAGE_SIZE (unpacked [0:IMAGE_SIZE-1])  pixel values.
NEW_IMAGE  in  1  start strobe; sampled only in IDLE.
THRESHOLD  in  [PIXEL_BITS:0]  pixels with value < THRESHOLD never spike.
MAX_SPIKES  in  [IMAGE_SIZE_BITS:0]  spike limit; 0 = unlimited.
DESCENDING  in  1  1 = largest value first; 0 = smallest first.
BUSY  out  1  high in every state except IDLE.
IMAGE_ENCODED  out  1  one-cycle pulse at end of image.
SPIKE_COUNT  out  [IMAGE_SIZE_BITS:0]  events emitted for current/last image.
AERIN_ADDR  out  [IMAGE_SIZE_BITS:0]  pixel index of current event.
AERIN_REQ  out  1  AER request.
AERIN_ACK  in  1  AER acknowledge.

Behaviour:
Reset:
- Applies to RST=1 at any edge, including mid-operation or mid-handshake.
- State = IDLE. BUSY, IMAGE_ENCODED, AERIN_REQ = 0. AERIN_ADDR = 0. SPIKE_COUNT = 0. Sent-mask cleared.
- AERIN_REQ drops at that edge regardless of AERIN_ACK.

Latching:
- On an edge in IDLE with NEW_IMAGE=1: register IMAGE, THRESHOLD, MAX_SPIKES, DESCENDING; clear sent-mask; SPIKE_COUNT=0; go to SELECT.
- Inputs are ignored after latching. NEW_IMAGE outside IDLE is ignored (no queueing).

Eligibility and selection:
- Eligible pixel = not sent AND value >= latched THRESHOLD (unsigned compare).
- Selection is combinational over all IMAGE_SIZE pixels.
- DESCENDING=1 picks the maximum value; DESCENDING=0 picks the minimum.
- Ties resolve to the lowest index.

FSM:
- IDLE: described under Latching.
- SELECT (exactly 1 cycle):
  - If no eligible pixel, or (MAX_SPIKES!=0 and SPIKE_COUNT==MAX_SPIKES): go to DONE.
  - Else: AERIN_ADDR <= index; AERIN_REQ <= 1; set mask bit; SPIKE_COUNT++; go to REQ.
- REQ: hold AERIN_REQ=1 and AERIN_ADDR stable. On an edge with AERIN_ACK=1: AERIN_REQ <= 0; go to ACK_LOW.
- ACK_LOW: wait for AERIN_ACK=0, then go to SELECT. AERIN_ADDR holds its value.
- DONE: IMAGE_ENCODED=1 for this cycle only; go to IDLE. SPIKE_COUNT holds until the next NEW_IMAGE.

Timing:
- NEW_IMAGE sampled at edge t gives AERIN_REQ=1 after edge t+1.
- With ACK asserted at edge a and deasserted at edge b, the next REQ rises after edge b+1.
- Empty image (no eligible pixel): IMAGE_ENCODED is high in the cycle after edge t+1; AERIN_REQ never rises.

Boundary conditions:
- AERIN_ACK already high on entering SELECT: REQ is still raised; the handshake completes at the next edge.
- Every pixel is emitted at most once.
- MAX_SPIKES > IMAGE_SIZE behaves as unlimited.
- THRESHOLD=0 makes all pixels eligible, including value 0.

Arithmetic:
- SPIKE_COUNT saturates at IMAGE_SIZE; it cannot exceed IMAGE_SIZE by construction.

Test Plan:
1. IMAGE={3,7,0,7,5}, THRESHOLD=1, MAX_SPIKES=0, DESCENDING=1, ACK returned after 1 cycle -> AERIN_ADDR sequence 1,3,4,0; SPIKE_COUNT=4; single IMAGE_ENCODED pulse after the 4th ACK falls.
2. Same image, THRESHOLD=0, DESCENDING=0 -> sequence 2,0,4,1,3; SPIKE_COUNT=5.
3. Same image, DESCENDING=1, MAX_SPIKES=2 -> sequence 1,3 only; SPIKE_COUNT=2; IMAGE_ENCODED follows.
4. THRESHOLD=8 -> AERIN_REQ never rises; IMAGE_ENCODED high in the 2nd cycle after the NEW_IMAGE edge; SPIKE_COUNT=0.
5. ACK held low for 10 cycles, then high for 3 cycles; NEW_IMAGE pulsed while BUSY -> REQ and ADDR stable throughout; REQ falls on the first ACK-high edge; next REQ waits for ACK low; the mid-run NEW_IMAGE is ignored.
6. RST=1 during REQ of the 2nd event -> next cycle REQ=0, ADDR=0, BUSY=0, SPIKE_COUNT=0; a new NEW_IMAGE restarts the sequence from the first-ranked pixel.

Source files
------------

// File: rtl/rank_order_encoder.sv
// -----------------------------------------------------------------------------
// rank_order_encoder
//
// Converts a latched pixel image into a rank-order spike train. Each eligible
// pixel (not yet sent, value >= latched threshold) is emitted once as an AER
// event carrying its pixel index, over a 4-phase REQ/ACK link. Pixels are
// ranked largest-first (DESCENDING=1) or smallest-first (DESCENDING=0), with
// ties going to the lowest index. An optional limit stops the train after
// MAX_SPIKES events (0 = unlimited).
//
// Ports
//   CLK            clock, all logic on the rising edge
//   RST            synchronous active-high reset
//   IMAGE          pixel values, unpacked [0:IMAGE_SIZE-1]
//   NEW_IMAGE      start strobe, only sampled in IDLE
//   THRESHOLD      pixels below this value never spike
//   MAX_SPIKES     spike limit, 0 = unlimited
//   DESCENDING     1 = largest value first, 0 = smallest first
//   BUSY           high whenever the encoder is not idle
//   IMAGE_ENCODED  one-cycle pulse when the image is finished
//   SPIKE_COUNT    events emitted for the current/last image
//   AERIN_ADDR     pixel index of the current event
//   AERIN_REQ      AER request
//   AERIN_ACK      AER acknowledge
//
// States
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | waiting for NEW_IMAGE; inputs latched on the strobe
//   S_SELECT  | one cycle: pick next ranked pixel or finish
//   S_REQ     | REQ high, address stable, waiting for ACK high
//   S_ACK_LOW | REQ low, waiting for ACK to return low
//   S_DONE    | IMAGE_ENCODED pulse, back to idle
// -----------------------------------------------------------------------------
module rank_order_encoder #(
    parameter int IMAGE_SIZE      = 5,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_MAX_VALUE = 10,
    parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [PIXEL_BITS:0]    IMAGE [0:IMAGE_SIZE-1],
    input  logic                   NEW_IMAGE,
    input  logic [PIXEL_BITS:0]    THRESHOLD,
    input  logic [IMAGE_SIZE_BITS:0] MAX_SPIKES,
    input  logic                   DESCENDING,
    output logic                   BUSY,
    output logic                   IMAGE_ENCODED,
    output logic [IMAGE_SIZE_BITS:0] SPIKE_COUNT,
    output logic [IMAGE_SIZE_BITS:0] AERIN_ADDR,
    output logic                   AERIN_REQ,
    input  logic                   AERIN_ACK
);

    localparam int W_ADDR = IMAGE_SIZE_BITS + 1;
    localparam logic [W_ADDR-1:0] COUNT_MAX = W_ADDR'(IMAGE_SIZE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_REQ     = 3'd2,
        S_ACK_LOW = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    logic [PIXEL_BITS:0]   r_image [0:IMAGE_SIZE-1];
    logic [PIXEL_BITS:0]   r_threshold;
    logic [W_ADDR-1:0]     r_max_spikes;
    logic                  r_descending;
    logic [IMAGE_SIZE-1:0] r_sent;
    logic [W_ADDR-1:0]     r_spike_count;
    logic [W_ADDR-1:0]     r_aer_addr;
    logic                  r_aer_req;
    logic                  r_image_encoded;

    logic                  w_found;
    logic [W_ADDR-1:0]     w_sel_idx;
    logic [PIXEL_BITS:0]   w_sel_val;
    logic [IMAGE_SIZE-1:0] w_sel_onehot;
    logic                  w_limit_hit;

    // Linear scan from index 0 upward. Only a strictly better value replaces
    // the current pick, so equal values keep the lowest index.
    always_comb begin
        w_found      = 1'b0;
        w_sel_idx    = '0;
        w_sel_val    = '0;
        w_sel_onehot = '0;
        for (int i = 0; i < IMAGE_SIZE; i++) begin
            if (!r_sent[i] && (r_image[i] >= r_threshold)) begin
                if (!w_found ||
                    (r_descending ? (r_image[i] > w_sel_val)
                                  : (r_image[i] < w_sel_val))) begin
                    w_found         = 1'b1;
                    w_sel_idx       = W_ADDR'(i);
                    w_sel_val       = r_image[i];
                    w_sel_onehot    = '0;
                    w_sel_onehot[i] = 1'b1;
                end
            end
        end
    end

    // A limit above IMAGE_SIZE is never reached, which makes it unlimited.
    assign w_limit_hit = (r_max_spikes != '0) && (r_spike_count == r_max_spikes);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= S_IDLE;
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                r_image[i] <= '0;
            end
            r_threshold     <= '0;
            r_max_spikes    <= '0;
            r_descending    <= 1'b0;
            r_sent          <= '0;
            r_spike_count   <= '0;
            r_aer_addr      <= '0;
            r_aer_req       <= 1'b0;
            r_image_encoded <= 1'b0;
        end else begin
            r_image_encoded <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (NEW_IMAGE) begin
                        r_image       <= IMAGE;
                        r_threshold   <= THRESHOLD;
                        r_max_spikes  <= MAX_SPIKES;
                        r_descending  <= DESCENDING;
                        r_sent        <= '0;
                        r_spike_count <= '0;
                        r_state       <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (!w_found || w_limit_hit) begin
                        r_image_encoded <= 1'b1;
                        r_state         <= S_DONE;
                    end else begin
                        r_aer_addr <= w_sel_idx;
                        r_aer_req  <= 1'b1;
                        r_sent     <= r_sent | w_sel_onehot;
                        if (r_spike_count < COUNT_MAX) begin
                            r_spike_count <= r_spike_count + W_ADDR'(1);
                        end
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (AERIN_ACK) begin
                        r_aer_req <= 1'b0;
                        r_state   <= S_ACK_LOW;
                    end
                end
                S_ACK_LOW: begin
                    if (!AERIN_ACK) begin
                        r_state <= S_SELECT;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_aer_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY          = (r_state != S_IDLE);
    assign IMAGE_ENCODED = r_image_encoded;
    assign SPIKE_COUNT   = r_spike_count;
    assign AERIN_ADDR    = r_aer_addr;
    assign AERIN_REQ     = r_aer_req;

endmodule
